// File: rtl/seq_adder_pkg.sv
// Shared types and sizing helpers for the digit-serial adder.
package seq_adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    // Number of DIGIT-wide slices in a WIDTH-bit operand.
    function automatic int num_digits(input int width, input int digit);
        return width / digit;
    endfunction

    // Slice counter width; a single-slice adder still needs a 1-bit counter.
    function automatic int cnt_width(input int nd);
        return (nd > 1) ? $clog2(nd) : 1;
    endfunction

endpackage

// File: rtl/seq_adder_digit_adder.sv
// Combinational DIGIT-bit ripple-carry slice; also exposes the carry into
// the slice MSB so the top level can form signed overflow on the last slice.
module digit_adder #(
    parameter int DIGIT = 4
) (
    input  logic [DIGIT-1:0] i_a,
    input  logic [DIGIT-1:0] i_b,
    input  logic             i_cin,
    output logic [DIGIT-1:0] o_sum,
    output logic             o_cout,
    output logic             o_cmsb
);

    logic [DIGIT:0] c;

    // Ripple through one full adder per bit.
    always_comb begin
        c     = '0;
        o_sum = '0;
        c[0]  = i_cin;
        for (int i = 0; i < DIGIT; i++) begin
            o_sum[i] = i_a[i] ^ i_b[i] ^ c[i];
            c[i+1]   = (i_a[i] & i_b[i]) | (c[i] & (i_a[i] ^ i_b[i]));
        end
    end

    assign o_cout = c[DIGIT];
    assign o_cmsb = c[DIGIT-1];

endmodule

// File: rtl/seq_adder.sv
// Digit-serial adder/subtractor: one DIGIT-bit slice per clock, LSB first,
// with valid/ready handshakes on request and result.
module seq_adder
    import seq_adder_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DIGIT = 4
) (
    input  logic             i_CLK,
    input  logic             i_RST,
    input  logic             i_VALID,
    output logic             o_READY,
    input  logic [WIDTH-1:0] i_A,
    input  logic [WIDTH-1:0] i_B,
    input  logic             i_SUB,
    input  logic             i_CIN,
    output logic             o_VALID,
    input  logic             i_READY,
    output logic [WIDTH-1:0] o_S,
    output logic             o_C,
    output logic             o_V
);

    localparam int D  = num_digits(WIDTH, DIGIT);
    localparam int CW = cnt_width(D);
    localparam logic [CW-1:0] LAST = CW'(D - 1);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;      // B already inverted for subtract
    logic [WIDTH-1:0] s_q, s_d;
    logic             carry_q, carry_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             c_q, c_d;
    logic             v_q, v_d;

    logic [DIGIT-1:0] slice_a, slice_b, slice_sum;
    logic             slice_cout, slice_cmsb;

    assign slice_a = a_q[int'(cnt_q)*DIGIT +: DIGIT];
    assign slice_b = b_q[int'(cnt_q)*DIGIT +: DIGIT];

    digit_adder #(.DIGIT(DIGIT)) u_digit (
        .i_a    (slice_a),
        .i_b    (slice_b),
        .i_cin  (carry_q),
        .o_sum  (slice_sum),
        .o_cout (slice_cout),
        .o_cmsb (slice_cmsb)
    );

    // Handshake, slice sequencing and result capture.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        s_d     = s_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;
        c_d     = c_q;
        v_d     = v_q;
        case (state_q)
            IDLE: begin
                if (i_VALID) begin
                    a_d     = i_A;
                    b_d     = i_SUB ? ~i_B : i_B;
                    carry_d = i_CIN;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                s_d[int'(cnt_q)*DIGIT +: DIGIT] = slice_sum;
                carry_d = slice_cout;
                if (cnt_q == LAST) begin
                    c_d     = slice_cout;
                    v_d     = slice_cmsb ^ slice_cout;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DONE: begin
                if (i_READY) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers; reset discards any in-flight operation.
    always_ff @(posedge i_CLK or posedge i_RST) begin
        if (i_RST) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            s_q     <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            c_q     <= 1'b0;
            v_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            s_q     <= s_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
            c_q     <= c_d;
            v_q     <= v_d;
        end
    end

    assign o_READY = (state_q == IDLE) & ~i_RST;
    assign o_VALID = (state_q == DONE);
    assign o_S     = s_q;
    assign o_C     = c_q;
    assign o_V     = v_q;

endmodule

// File: tb/tb_seq_adder.sv
// Self-checking bench for seq_adder at WIDTH=16, DIGIT=4.
module tb_seq_adder;

    localparam int W = 16;
    localparam int G = 4;
    localparam int D = W / G;

    logic         i_CLK = 1'b0;
    logic         i_RST = 1'b1;
    logic         i_VALID = 1'b0;
    logic         o_READY;
    logic [W-1:0] i_A = '0;
    logic [W-1:0] i_B = '0;
    logic         i_SUB = 1'b0;
    logic         i_CIN = 1'b0;
    logic         o_VALID;
    logic         i_READY = 1'b0;
    logic [W-1:0] o_S;
    logic         o_C;
    logic         o_V;

    int total = 0;
    int bad   = 0;

    seq_adder #(.WIDTH(W), .DIGIT(G)) dut (
        .i_CLK   (i_CLK),
        .i_RST   (i_RST),
        .i_VALID (i_VALID),
        .o_READY (o_READY),
        .i_A     (i_A),
        .i_B     (i_B),
        .i_SUB   (i_SUB),
        .i_CIN   (i_CIN),
        .o_VALID (o_VALID),
        .i_READY (i_READY),
        .o_S     (o_S),
        .o_C     (o_C),
        .o_V     (o_V)
    );

    always #5 i_CLK = ~i_CLK;

    typedef struct {
        string      name;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic       sub;
        logic       cin;
        logic [W-1:0] s;
        logic       c;
        logic       v;
    } vec_t;

    vec_t tbl[5];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference: plain integer arithmetic; overflow from operand/result signs.
    function automatic logic [W+1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic sub, input logic cin);
        logic [W-1:0] bb;
        logic [W:0]   r;
        logic         v;
        bb = sub ? ~b : b;
        r  = {1'b0, a} + {1'b0, bb} + {{W{1'b0}}, cin};
        v  = (a[W-1] == bb[W-1]) && (r[W-1] != a[W-1]);
        return {r[W], v, r[W-1:0]};
    endfunction

    // Issue one request, wait for the result, check latency, then consume it.
    task automatic run_op(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic sub, input logic cin, output logic [W+1:0] res);
        int n;
        n = 0;
        while (!o_READY && n < 50) begin
            @(posedge i_CLK); #1; n++;
        end
        chk({name, " ready"}, 32'(o_READY), 32'd1);
        i_VALID = 1'b1; i_A = a; i_B = b; i_SUB = sub; i_CIN = cin;
        @(posedge i_CLK); #1;
        i_VALID = 1'b0;
        i_A = W'($urandom); i_B = W'($urandom);
        i_SUB = 1'($urandom); i_CIN = 1'($urandom);
        n = 0;
        while (!o_VALID && n < 50) begin
            @(posedge i_CLK); #1; n++;
        end
        chk({name, " latency"}, 32'(n), 32'(D));
        res = {o_C, o_V, o_S};
        i_READY = 1'b1;
        @(posedge i_CLK); #1;
        i_READY = 1'b0;
        chk({name, " handoff"}, {30'd0, o_VALID, o_READY}, 32'b01);
    endtask

    initial begin
        logic [W+1:0] res, exp, hold;
        int n;

        tbl[0] = '{"add",      16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0};
        tbl[1] = '{"ripple",   16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
        tbl[2] = '{"ovf_add",  16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1};
        tbl[3] = '{"sub_neg",  16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0};
        tbl[4] = '{"ovf_sub",  16'h8000, 16'h0001, 1'b1, 1'b1, 16'h7FFF, 1'b1, 1'b1};

        // Reset state.
        #12;
        chk("reset outs", {13'd0, o_READY, o_VALID, o_C, o_V, o_S}, 32'd0);
        i_RST = 1'b0;
        #1;
        chk("ready after reset", 32'(o_READY), 32'd1);
        @(posedge i_CLK); #1;

        // Directed vectors.
        for (int i = 0; i < 5; i++) begin
            run_op(tbl[i].name, tbl[i].a, tbl[i].b, tbl[i].sub, tbl[i].cin, res);
            chk({tbl[i].name, " result"}, 32'(res), 32'({tbl[i].c, tbl[i].v, tbl[i].s}));
        end

        // Random operands against the reference model.
        for (int i = 0; i < 30; i++) begin
            logic [W-1:0] ra, rb;
            logic rs, rc;
            ra = W'($urandom); rb = W'($urandom);
            rs = 1'($urandom); rc = 1'($urandom);
            if (i < 4) begin
                ra = (i[0]) ? 16'h8000 : 16'h7FFF;
                rb = (i[1]) ? 16'h7FFF : 16'hFFFF;
            end
            run_op("rand", ra, rb, rs, rc, res);
            exp = model(ra, rb, rs, rc);
            chk("rand result", 32'(res), 32'(exp));
        end

        // Backpressure: hold result for 5 cycles while new requests are offered.
        i_VALID = 1'b1; i_A = 16'h0F0F; i_B = 16'h00F1; i_SUB = 1'b0; i_CIN = 1'b1;
        @(posedge i_CLK); #1;
        n = 0;
        while (!o_VALID && n < 50) begin
            @(posedge i_CLK); #1; n++;
        end
        chk("bp reach done", 32'(o_VALID), 32'd1);
        hold = {o_C, o_V, o_S};
        chk("bp result", 32'(hold), 32'(model(16'h0F0F, 16'h00F1, 1'b0, 1'b1)));
        for (int k = 0; k < 5; k++) begin
            i_A = W'($urandom); i_B = W'($urandom);
            @(posedge i_CLK); #1;
            chk("bp stable", {13'd0, o_READY, o_VALID, o_C, o_V, o_S},
                {13'd0, 1'b0, 1'b1, hold});
        end
        i_VALID = 1'b0;
        i_READY = 1'b1;
        @(posedge i_CLK); #1;
        i_READY = 1'b0;
        chk("bp release", {30'd0, o_VALID, o_READY}, 32'b01);
        run_op("bp next", 16'h1111, 16'h2222, 1'b1, 1'b1, res);
        chk("bp next result", 32'(res), 32'(model(16'h1111, 16'h2222, 1'b1, 1'b1)));

        // Reset while slice 2 is in flight.
        i_VALID = 1'b1; i_A = 16'hABCD; i_B = 16'h1357; i_SUB = 1'b0; i_CIN = 1'b0;
        @(posedge i_CLK); #1;
        i_VALID = 1'b0;
        @(posedge i_CLK); @(posedge i_CLK); #1;
        i_RST = 1'b1;
        #1;
        chk("midrun reset", {13'd0, o_READY, o_VALID, o_C, o_V, o_S}, 32'd0);
        @(posedge i_CLK); #3;
        i_RST = 1'b0;
        #1;
        chk("midrun ready", {30'd0, o_VALID, o_READY}, 32'b01);
        run_op("post reset", 16'h00FF, 16'h0001, 1'b0, 1'b0, res);
        chk("post reset result", 32'(res), 32'({1'b0, 1'b0, 16'h0100}));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
